// File: rtl/digit_frame_loader_pkg.sv
// Shared constants and types for the double-buffered digit frame loader.
// Two 784-pixel banks, 10-bit classifier read index, 8-bit pixels.
package digit_frame_pkg;

  localparam int PIXELS_PER_FRAME = 784;
  localparam int LAST_IDX         = 783;
  localparam int PIXEL_W          = 8;
  localparam int ADDR_W           = 10;
  localparam int RD_DATA_W        = 16;
  localparam int RAM_DEPTH        = 2 * PIXELS_PER_FRAME;
  localparam int RAM_AW           = 11;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0]  idx_t;
  typedef logic               bank_t;

  // Banks are packed back to back so the RAM is exactly 1568 deep.
  function automatic logic [RAM_AW-1:0] ram_addr(
    input bank_t b,
    input idx_t  i
  );
    logic [RAM_AW-1:0] base;
    base = b ? RAM_AW'(PIXELS_PER_FRAME) : '0;
    return base + RAM_AW'(i);
  endfunction

endpackage

// File: rtl/digit_frame_loader_if.sv
// Pixel stream ready/valid interface feeding the frame loader.
// master: pixel source (valid/data/last out); slave: loader (ready out).
interface digit_frame_loader_if;
  import digit_frame_pkg::*;

  logic   pix_valid;
  logic   pix_ready;
  pixel_t pix_data;
  logic   pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    output pix_ready
  );

endinterface

// File: rtl/digit_frame_loader_frame_ram_sdp.sv
// Simple dual-port 1568x8 frame RAM, one write port, one sync read port.
// Ports: clk, we/wr_bank/wr_idx/wdata (write), rd_bank/rd_idx/rdata (read).
module frame_ram_sdp
  import digit_frame_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  bank_t  wr_bank,
  input  idx_t   wr_idx,
  input  pixel_t wdata,
  input  bank_t  rd_bank,
  input  idx_t   rd_idx,
  output pixel_t rdata
);

  pixel_t mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[ram_addr(wr_bank, wr_idx)] <= wdata;
    rdata <= mem[ram_addr(rd_bank, rd_idx)];
  end

endmodule

// File: rtl/digit_frame_loader.sv
// Double-buffered 28x28 frame loader ahead of the digit classifier.
// Ports: clk, reset, pix (stream slave), classifier RAM/flag port,
// frame_count, frame_err. FRAME_LOADER_LAST_CHECK_EN enables pix_last
// framing checks; without it pix_last is ignored and frame_err is 0.
module digit_frame_loader
  import digit_frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  digit_frame_loader_if.slave  pix,
  input  logic [ADDR_W-1:0]    classifier_input_address_a,
  output logic [RD_DATA_W-1:0] classifier_input_read_data_a,
  output logic [7:0]           classifier_input_valid_read_data,
  input  logic                 classifier_input_valid_write_en,
  input  logic [7:0]           classifier_input_valid_write_data,
  output logic [15:0]          frame_count,
  output logic                 frame_err
);

  bank_t      wr_bank;
  bank_t      rd_bank;
  logic [1:0] full;
  logic [1:0] full_nxt;
  idx_t       wr_idx;
  logic       rd_ok_q;
  pixel_t     ram_q;
  idx_t       rd_idx;
  logic       rd_in_range;
  logic       accept;
  logic       at_last;
  logic       commit;
  logic       drop;
  logic       rel_ok;
  logic       unused_bits;

  assign pix.pix_ready = ~reset & ~full[wr_bank];

  assign accept  = pix.pix_valid & pix.pix_ready;
  assign at_last = (wr_idx == idx_t'(LAST_IDX));
  assign commit  = accept & at_last;

  // The consumer may only clear its flag; a "set" write is a no-op.
  assign rel_ok = classifier_input_valid_write_en
                & ~classifier_input_valid_write_data[0]
                & full[rd_bank];

`ifdef FRAME_LOADER_LAST_CHECK_EN
  logic bad_frame;
  assign drop      = accept & pix.pix_last & ~at_last;
  assign bad_frame = drop | (commit & ~pix.pix_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_err <= 1'b0;
    else if (bad_frame)
      frame_err <= 1'b1;
  end

  assign unused_bits = ^classifier_input_valid_write_data[7:1];
`else
  assign drop        = 1'b0;
  assign frame_err   = 1'b0;
  assign unused_bits = ^{classifier_input_valid_write_data[7:1],
                         pix.pix_last};
`endif

  // Commit and release always hit different banks when both fire.
  always_comb begin
    full_nxt = full;
    if (commit)
      full_nxt[wr_bank] = 1'b1;
    if (rel_ok)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      wr_idx      <= '0;
      frame_count <= '0;
      rd_ok_q     <= 1'b0;
    end else begin
      full    <= full_nxt;
      rd_ok_q <= rd_in_range;
      if (commit || drop)
        wr_idx <= '0;
      else if (accept)
        wr_idx <= wr_idx + 1'b1;
      if (commit) begin
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 16'd1;
      end
      if (rel_ok)
        rd_bank <= ~rd_bank;
    end
  end

  // Out-of-range reads are masked so the RAM index never overruns.
  assign rd_in_range = classifier_input_address_a
                       < ADDR_W'(PIXELS_PER_FRAME);
  assign rd_idx = rd_in_range ? classifier_input_address_a : '0;

  frame_ram_sdp u_ram (
    .clk     (clk),
    .we      (accept),
    .wr_bank (wr_bank),
    .wr_idx  (wr_idx),
    .wdata   (pix.pix_data),
    .rd_bank (rd_bank),
    .rd_idx  (rd_idx),
    .rdata   (ram_q)
  );

  assign classifier_input_read_data_a = rd_ok_q
    ? {{(RD_DATA_W-PIXEL_W){1'b0}}, ram_q} : '0;

  assign classifier_input_valid_read_data = {7'b0, full[rd_bank]};

endmodule
